// File: rtl/m_arb_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : m_arb_mux_n
// Description : Parametrised N:1 data multiplexer with per-channel
//               valid/ready handshake and a one-entry output register.
//               Arbitrated mode (i_mode=0) picks among requesting channels.
//               Forced mode (i_mode=1) follows i_select.
//
//               Build option M_ARB_MUX_ROUND_ROBIN_EN:
//                 defined   - arbitrated mode searches upward from a rotating
//                             pointer that moves past the last winner
//                 undefined - arbitrated mode is fixed priority, and the
//                             lowest valid index wins
//
// Ports       : i_clk     - clock, rising edge
//               i_rst_n   - asynchronous active-low reset
//               i_data    - flattened channel data, ch k at [k*WIDTH +: WIDTH]
//               i_valid   - per-channel request
//               o_ready   - per-channel accept (at most one bit high)
//               i_mode    - 0 = arbitrated, 1 = forced select
//               i_select  - channel index used in forced mode
//               o_data    - registered output word
//               o_valid   - output register holds valid data
//               i_ready   - downstream accept
//               o_sel     - channel index of the word in o_data
// Revision    : 1.0 - initial release
// ============================================================================
module m_arb_mux_n #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       o_ready,
    input  logic                      i_mode,
    input  logic [SEL_W-1:0]          i_select,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [SEL_W-1:0]          o_sel
);

    // One extra bit so that CHANNELS itself is representable for the
    // range check and the wrap-around of the search index.
    localparam logic [SEL_W:0] c_channels = (SEL_W + 1)'(CHANNELS);

    // ------------------------------------------------------------------
    // Channel data unpacking
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_ch_data [CHANNELS];

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
            assign w_ch_data[k] = i_data[k*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Search start point for arbitrated mode
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] w_search_base;
    logic             w_load_ok;
    logic             w_grant_any;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_xfer;

`ifdef M_ARB_MUX_ROUND_ROBIN_EN
    localparam logic [SEL_W-1:0] c_last = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] r_ptr;

    // The pointer moves only on arbitrated transfers; forced-mode transfers
    // leave the rotation untouched. Wrap is at CHANNELS, not 2^SEL_W.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer && !i_mode) begin
            r_ptr <= (w_grant_idx == c_last) ? '0 : SEL_W'(w_grant_idx + 1'b1);
        end
    end

    assign w_search_base = r_ptr;
`else
    assign w_search_base = '0;
`endif

    // ------------------------------------------------------------------
    // Arbitrated-mode search: first valid channel at or above the base,
    // wrapping modulo CHANNELS.
    // ------------------------------------------------------------------
    logic [SEL_W:0]   w_cand;
    logic             w_arb_found;
    logic [SEL_W-1:0] w_arb_idx;

    always_comb begin
        w_cand      = '0;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int off = 0; off < CHANNELS; off++) begin
            w_cand = {1'b0, w_search_base} + (SEL_W + 1)'(off);
            if (w_cand >= c_channels) begin
                w_cand = w_cand - c_channels;
            end
            if (!w_arb_found && i_valid[w_cand[SEL_W-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand[SEL_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Forced-mode grant: an out-of-range select never grants.
    // ------------------------------------------------------------------
    logic w_force_ok;

    always_comb begin
        w_force_ok = 1'b0;
        if ({1'b0, i_select} < c_channels) begin
            w_force_ok = i_valid[i_select];
        end
    end

    // ------------------------------------------------------------------
    // Grant and handshake. o_ready depends only on valids, mode, select,
    // pointer and the output register state, never on i_data.
    // ------------------------------------------------------------------
    assign w_load_ok   = !o_valid || i_ready;
    assign w_grant_any = i_mode ? w_force_ok : w_arb_found;
    assign w_grant_idx = i_mode ? i_select   : w_arb_idx;
    assign w_xfer      = w_grant_any && w_load_ok;
    assign o_ready     = w_xfer ? (CHANNELS'(1) << w_grant_idx) : '0;

    // ------------------------------------------------------------------
    // Output register. A load may coincide with a drain. A drain with no
    // load clears only o_valid, so o_data and o_sel keep the last word.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_sel   <= '0;
        end else if (w_xfer) begin
            o_valid <= 1'b1;
            o_data  <= w_ch_data[w_grant_idx];
            o_sel   <= w_grant_idx;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_arb_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_m_arb_mux_n
// Description : Self-checking bench for m_arb_mux_n. Two instances run side
//               by side: a 4-channel one and a 3-channel one, the second
//               covering a non-power-of-two channel count. A transaction-level
//               reference model predicts o_ready and the output register.
//               Directed scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m_arb_mux_n;

    localparam int W = 32;
`ifdef M_ARB_MUX_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 4-channel instance
    logic [4*W-1:0] a_data;
    logic [3:0]     a_valid, a_ready_o;
    logic           a_mode, a_rdy_in, a_vout;
    logic [1:0]     a_sel_in, a_sel_out;
    logic [W-1:0]   a_dout;

    // 3-channel instance
    logic [3*W-1:0] b_data;
    logic [2:0]     b_valid, b_ready_o;
    logic           b_mode, b_rdy_in, b_vout;
    logic [1:0]     b_sel_in, b_sel_out;
    logic [W-1:0]   b_dout;

    m_arb_mux_n #(.WIDTH(W), .CHANNELS(4)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(a_data), .i_valid(a_valid),
        .o_ready(a_ready_o), .i_mode(a_mode), .i_select(a_sel_in),
        .o_data(a_dout), .o_valid(a_vout), .i_ready(a_rdy_in), .o_sel(a_sel_out)
    );

    m_arb_mux_n #(.WIDTH(W), .CHANNELS(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(b_data), .i_valid(b_valid),
        .o_ready(b_ready_o), .i_mode(b_mode), .i_select(b_sel_in),
        .o_data(b_dout), .o_valid(b_vout), .i_ready(b_rdy_in), .o_sel(b_sel_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: output register contents and arbitration pointer
    // ------------------------------------------------------------------
    bit          m_valid [2];
    logic [31:0] m_data  [2];
    int          m_sel   [2];
    int          m_ptr   [2];

    task automatic model_reset(input int id);
        m_valid[id] = 1'b0;
        m_data[id]  = '0;
        m_sel[id]   = 0;
        m_ptr[id]   = 0;
    endtask

    // Winning channel index, or -1 when nothing is granted
    function automatic int arb(input int n, input logic [3:0] v, input logic mode,
                               input int sel, input int ptr);
        if (mode) return (sel < n && v[sel]) ? sel : -1;
        for (int off = 0; off < n; off++) begin
            int k;
            k = (ptr + off) % n;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_dut(input string pfx, input int id, input int n,
                             input logic [3:0] v, input logic mode, input int sel,
                             input logic rdy_in, input logic [3:0] rdy_out,
                             input logic vout, input logic [31:0] dout, input int selout);
        int         g;
        logic       load_ok;
        logic [3:0] exp_rdy;
        load_ok = !m_valid[id] || rdy_in;
        g       = arb(n, v, mode, sel, m_ptr[id]);
        exp_rdy = (g >= 0 && load_ok) ? 4'(1 << g) : 4'd0;
        check({pfx, "_ready"}, 32'(rdy_out), 32'(exp_rdy));
        check({pfx, "_valid"}, 32'(vout), 32'(m_valid[id]));
        check({pfx, "_data"},  dout, m_data[id]);
        check({pfx, "_sel"},   32'(selout), 32'(m_sel[id]));
    endtask

    task automatic update_dut(input int id, input int n, input logic [127:0] d,
                              input logic [3:0] v, input logic mode, input int sel,
                              input logic rdy_in);
        int   g;
        logic load_ok;
        if (!rst_n) begin
            model_reset(id);
        end else begin
            load_ok = !m_valid[id] || rdy_in;
            g       = arb(n, v, mode, sel, m_ptr[id]);
            if (g >= 0 && load_ok) begin
                m_valid[id] = 1'b1;
                m_data[id]  = d[g*32 +: 32];
                m_sel[id]   = g;
                if (!mode && RR) m_ptr[id] = (g + 1) % n;
            end else if (m_valid[id] && rdy_in) begin
                m_valid[id] = 1'b0;
            end
        end
    endtask

    // Inputs are driven at the falling edge. Each cycle is checked just
    // after that edge, and the model then advances with the rising edge.
    task automatic cycle();
        #1;
        check_dut("a", 0, 4, a_valid, a_mode, int'(a_sel_in), a_rdy_in,
                  a_ready_o, a_vout, a_dout, int'(a_sel_out));
        check_dut("b", 1, 3, {1'b0, b_valid}, b_mode, int'(b_sel_in), b_rdy_in,
                  {1'b0, b_ready_o}, b_vout, b_dout, int'(b_sel_out));
        @(posedge clk);
        update_dut(0, 4, a_data, a_valid, a_mode, int'(a_sel_in), a_rdy_in);
        update_dut(1, 3, {32'd0, b_data}, {1'b0, b_valid}, b_mode, int'(b_sel_in), b_rdy_in);
        @(negedge clk);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < 4; k++) a_data[k*32 +: 32] = $urandom;
        for (int k = 0; k < 3; k++) b_data[k*32 +: 32] = $urandom;
    endtask

    logic [31:0] exp_word;

    initial begin
        rst_n    = 1'b0;
        a_data   = '0; a_valid = '0; a_mode = 1'b0; a_sel_in = '0; a_rdy_in = 1'b1;
        b_data   = '0; b_valid = '0; b_mode = 1'b0; b_sel_in = '0; b_rdy_in = 1'b1;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        repeat (2) cycle();
        rst_n = 1'b1;

        // Rotation with every channel requesting
        randomize_data();
        a_valid = 4'hF;
        b_valid = 3'h7;
        for (int j = 0; j < 6; j++) begin
            cycle();
            check("rr_a_seq", 32'(a_sel_out), RR ? 32'(j % 4) : 32'd0);
            check("rr_b_seq", 32'(b_sel_out), RR ? 32'(j % 3) : 32'd0);
        end
        a_valid = '0;
        b_valid = '0;
        cycle();

        // Single requesting channel
        randomize_data();
        a_data[64 +: 32] = 32'hDEADBEEF;
        a_valid = 4'b0100;
        #1 check("single_ready", 32'(a_ready_o), 32'h4);
        cycle();
        check("single_data", a_dout, 32'hDEADBEEF);
        check("single_sel", 32'(a_sel_out), 32'd2);
        check("single_vout", 32'(a_vout), 32'd1);

        // Backpressure while the ch1 word is held
        a_valid = 4'b0010;
        a_data[32 +: 32] = 32'h11;
        cycle();
        a_rdy_in = 1'b0;
        a_valid  = 4'hF;
        for (int j = 0; j < 3; j++) begin
            #1 check("bp_ready", 32'(a_ready_o), 32'd0);
            cycle();
            check("bp_data", a_dout, 32'h11);
            check("bp_sel", 32'(a_sel_out), 32'd1);
        end
        a_rdy_in = 1'b1;
        #1 check("bp_release_ready", 32'(a_ready_o), RR ? 32'h4 : 32'h1);
        exp_word = RR ? a_data[64 +: 32] : a_data[0 +: 32];
        cycle();
        check("bp_next_data", a_dout, exp_word);
        check("bp_next_sel", 32'(a_sel_out), RR ? 32'd2 : 32'd0);

        // Forced select
        a_mode = 1'b1; a_sel_in = 2'd3; a_valid = 4'b1001;
        b_mode = 1'b1; b_sel_in = 2'd3; b_valid = 3'b111;
        #1 check("force_ready", 32'(a_ready_o), 32'h8);
        check("force_b_oor_ready", 32'(b_ready_o), 32'd0);
        cycle();
        check("force_sel", 32'(a_sel_out), 32'd3);
        a_valid = 4'b0001;
        #1 check("force_noreq_ready", 32'(a_ready_o), 32'd0);
        cycle();
        check("force_drain_vout", 32'(a_vout), 32'd0);
        check("force_drain_sel", 32'(a_sel_out), 32'd3);
        a_mode = 1'b0; b_mode = 1'b0;
        a_sel_in = '0; b_sel_in = '0;

        // Asynchronous reset while a word is held
        randomize_data();
        a_valid = 4'hF;
        b_valid = 3'h7;
        a_rdy_in = 1'b0;
        cycle();
        check("pre_rst_vout", 32'(a_vout), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vout", 32'(a_vout), 32'd0);
        check("arst_data", a_dout, 32'd0);
        check("arst_sel", 32'(a_sel_out), 32'd0);
        check("arst_b_vout", 32'(b_vout), 32'd0);
        model_reset(0);
        model_reset(1);
        a_valid = '0;
        b_valid = '0;
        a_rdy_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 4'hF;
        b_valid = 3'h7;
        cycle();
        check("post_rst_sel", 32'(a_sel_out), 32'd0);

        // Randomized traffic
        for (int j = 0; j < 400; j++) begin
            randomize_data();
            a_valid  = 4'($urandom);
            b_valid  = 3'($urandom);
            a_mode   = ($urandom_range(0, 3) == 0);
            b_mode   = ($urandom_range(0, 3) == 0);
            a_sel_in = 2'($urandom);
            b_sel_in = 2'($urandom);
            a_rdy_in = ($urandom_range(0, 3) != 0);
            b_rdy_in = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_arb_mux_n.md
Name: m_arb_mux_n

Overview:
- Parametrised, registered N:1 data multiplexer with per-channel valid/ready handshake.
- Next generation of the combinational 2:1/4:1 multiplexors.
- Either arbitrates among requesting channels (arbitrated mode) or follows an explicit select (forced mode).
- Output passes through a one-entry register stage.
- Used wherever several 32-bit producers share one consumer, e.g. memory-port or writeback sharing.

Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), width of select/index signals; localparam, not overridable.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_data  input  CHANNELS*WIDTH  flattened channel data; channel k at [k*WIDTH +: WIDTH].
- i_valid  input  CHANNELS  per-channel request/valid.
- o_ready  output  CHANNELS  per-channel accept; at most one bit high.
- i_mode  input  1  0 = arbitrated, 1 = forced select.
- i_select  input  SEL_W  channel index used in forced mode.
- o_data  output  WIDTH  registered output data.
- o_valid  output  1  output register holds valid data.
- i_ready  input  1  downstream accept.
- o_sel  output  SEL_W  index of the channel whose data is in o_data.

Behaviour:
- Reset (i_rst_n low, asynchronous): o_valid=0, o_data=0, o_sel=0, round-robin pointer=0. o_ready is combinational and therefore 0 while o_valid=0 and no i_valid is high.
- load_ok = !o_valid || i_ready. This is a one-entry pipeline register, so a simultaneous drain and load is allowed.
- Grant (combinational, one-hot or zero):
  - Arbitrated mode: first k with i_valid[k]=1, searching from the pointer upward with wrap-around CHANNELS-1 -> 0.
  - Forced mode: grant[i_select] = i_valid[i_select]. If i_select >= CHANNELS, no grant.
- o_ready[k] = grant[k] && load_ok. o_ready must not depend combinationally on i_data.
- Transfer on channel k: i_valid[k] && o_ready[k] at a rising edge. The next cycle has o_data = channel k data, o_sel = k, o_valid = 1. Latency is 1 cycle input-to-output.
- Output consumed with no new load: o_valid && i_ready with no grant sets o_valid to 0. o_data and o_sel keep their last values.
- Backpressure: when o_valid=1 and i_ready=0, o_data, o_sel and o_valid stay stable and all o_ready bits are 0.
- Throughput: one word per cycle while i_ready=1 and any granted channel is valid.
- Pointer update (arbitrated mode only): after a transfer from k, pointer = (k+1) mod CHANNELS. The pointer is unchanged in forced mode and in cycles with no transfer.
- Mode or select change mid-stream: affects only the next grant. The held output word is unaffected.
- A channel whose i_valid drops before it is granted is simply skipped. There is no state per channel.
- CHANNELS not a power of two: pointer wrap uses modulo CHANNELS, never 2^SEL_W.

Optional Feature:
- Macro M_ARB_MUX_ROUND_ROBIN_EN.
- Defined: arbitrated mode uses the rotating pointer described above.
- Undefined: arbitrated mode is fixed priority, lowest valid index wins. The pointer register is not implemented and the search always starts at channel 0.
- Forced mode is identical in both builds.

Test Plan:
- Reset: assert i_rst_n=0 mid-transfer with o_valid=1 -> o_valid, o_data, o_sel go to 0 immediately, without waiting for a clock edge.
- Single channel: CHANNELS=4, i_valid=0100, i_data ch2=32'hDEADBEEF, i_ready=1 -> o_ready=0100; next cycle o_valid=1, o_data=DEADBEEF, o_sel=2.
- Round robin (macro defined): i_valid=1111 held, i_ready=1 -> o_sel sequence 0,1,2,3,0,1 on consecutive cycles. Fixed priority (macro undefined) with the same stimulus -> o_sel stays 0 every cycle.
- Backpressure: o_valid=1 holding ch1 word 32'h11, i_ready=0 for 3 cycles with i_valid=1111 -> o_data=11, o_sel=1 stable and o_ready=0000. When i_ready=1, the same cycle shows o_ready=0100 (pointer=2), and ch2 data appears next cycle.
- Forced mode: i_mode=1, i_select=3, i_valid=1001 -> only ch3 granted, o_sel=3. With i_select=3 and i_valid=0001 -> no grant, and o_valid drops after consumption.
- Non-power-of-two: CHANNELS=3, all valid, macro defined -> o_sel sequence 0,1,2,0. Forced i_select=3 -> no grant.
